// File: rtl/ccsds_rs_frame_sync.sv
// CCSDS TM frame synchroniser: finds the attached sync marker in a byte stream,
// confirms lock with a search/check/lock FSM plus flywheel, and emits codeblocks with framing flags.
module ccsds_rs_frame_sync #(
  parameter logic [31:0] ASM         = 32'h1ACFFC1D,
  parameter int unsigned CB_LEN      = 1275,
  parameter int unsigned PARITY_LEN  = 160,
  parameter int unsigned CHECK_COUNT = 2,
  parameter int unsigned FLYWHEEL    = 3,
  parameter int unsigned CNT_WIDTH   = 11
) (
  input  logic       nGrst,
  input  logic       clk,
  input  logic       rst,
  input  logic       clkEn,
  input  logic [7:0] din,
  input  logic       dinValid,
  output logic [7:0] dout,
  output logic       doutValid,
  output logic       sof,
  output logic       eof,
  output logic       parity,
  output logic       locked,
  output logic [1:0] state,
  output logic       lockLost
);

  localparam int unsigned GW = $clog2(CHECK_COUNT + 1);
  localparam int unsigned MW = $clog2(FLYWHEEL + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t               st_q, st_d;
  logic [23:0]          sh_q, sh_d;
  logic [CNT_WIDTH-1:0] pos_q, pos_d;
  logic [GW-1:0]        good_q, good_d, good_inc;
  logic [MW-1:0]        miss_q, miss_d, miss_inc;
  logic [7:0]           dout_q, dout_d;
  logic                 vld_q, vld_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;
  logic                 par_q, par_d;
  logic                 lost_q, lost_d;
  logic                 locked_q, locked_d;
  logic                 match;
  logic                 at_end;

  // Window includes the byte being accepted so the hit lands on the last marker byte.
  assign match    = ({sh_q, din} == ASM);
  assign at_end   = (pos_q == CNT_WIDTH'(CB_LEN + 3));
  assign good_inc = good_q + GW'(1);
  assign miss_inc = miss_q + MW'(1);

  // State register and output registers; sync reset beats the enable.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      st_q     <= SEARCH;
      sh_q     <= '0;
      pos_q    <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      par_q    <= 1'b0;
      lost_q   <= 1'b0;
      locked_q <= 1'b0;
    end else if (rst) begin
      st_q     <= SEARCH;
      sh_q     <= '0;
      pos_q    <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      par_q    <= 1'b0;
      lost_q   <= 1'b0;
      locked_q <= 1'b0;
    end else if (clkEn) begin
      st_q     <= st_d;
      sh_q     <= sh_d;
      pos_q    <= pos_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      par_q    <= par_d;
      lost_q   <= lost_d;
      locked_q <= locked_d;
    end
  end

  // Next-state and next-output logic for one accepted byte.
  always_comb begin
    st_d   = st_q;
    sh_d   = sh_q;
    pos_d  = pos_q;
    good_d = good_q;
    miss_d = miss_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    sof_d  = 1'b0;
    eof_d  = 1'b0;
    par_d  = 1'b0;
    lost_d = 1'b0;

    if (dinValid) begin
      sh_d  = {sh_q[15:0], din};
      pos_d = at_end ? '0 : pos_q + CNT_WIDTH'(1);
      unique case (st_q)
        SEARCH: begin
          if (match) begin
            st_d   = CHECK;
            pos_d  = '0;
            good_d = '0;
          end
        end
        CHECK: begin
          if (at_end) begin
            if (!match) begin
              st_d = SEARCH;
            end else if (good_inc == GW'(CHECK_COUNT)) begin
              st_d   = LOCK;
              good_d = good_inc;
              miss_d = '0;
            end else begin
              good_d = good_inc;
            end
          end
        end
        LOCK: begin
          if (pos_q < CNT_WIDTH'(CB_LEN)) begin
            vld_d  = 1'b1;
            dout_d = din;
            sof_d  = (pos_q == '0);
            eof_d  = (pos_q == CNT_WIDTH'(CB_LEN - 1));
            par_d  = (pos_q >= CNT_WIDTH'(CB_LEN - PARITY_LEN));
          end
          if (at_end) begin
            if (match) begin
              miss_d = '0;
            end else if (miss_inc == MW'(FLYWHEEL)) begin
              st_d   = SEARCH;
              lost_d = 1'b1;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: st_d = SEARCH;
      endcase
    end

    locked_d = (st_d == LOCK);
  end

  assign dout      = dout_q;
  assign doutValid = vld_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign parity    = par_q;
  assign lockLost  = lost_q;
  assign locked    = locked_q;
  assign state     = st_q;

endmodule
